// File: rtl/ste_stream_sequencer.sv
// ============================================================================
// ste_stream_sequencer
//   Steps one symbol stream through an STE array and queues non-zero report
//   vectors, tagged with their symbol offset, in a show-ahead report FIFO.
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module ste_stream_sequencer #(
  parameter int SYM_W      = 8,
  parameter int REPORT_W   = 16,
  parameter int OFFSET_W   = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [SYM_W-1:0]    s_data,
  input  logic                s_last,
  input  logic                cfg_all_input,
  output logic [SYM_W-1:0]    sym_out,
  output logic                ste_run,
  output logic                ste_sod,
  output logic                ste_reset,
  input  logic [REPORT_W-1:0] report_vec,
  output logic                r_valid,
  input  logic                r_ready,
  output logic [OFFSET_W-1:0] r_offset,
  output logic [REPORT_W-1:0] r_bits,
  output logic                busy,
  output logic                done
);

  localparam int c_PTR_W   = $clog2(FIFO_DEPTH);
  localparam int c_CNT_W   = c_PTR_W + 1;
  localparam int c_ENTRY_W = OFFSET_W + REPORT_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CLR  = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                r_state;
  logic                  r_sym_vld;
  logic                  r_last_held;
  logic                  r_cfg;
  logic [SYM_W-1:0]      r_sym;
  logic [OFFSET_W-1:0]   r_sym_offset;
  logic                  r_ste_reset;
  logic                  r_busy;
  logic                  r_done;
  logic [c_ENTRY_W-1:0]  r_mem [FIFO_DEPTH];
  logic [c_PTR_W-1:0]    r_wr_ptr;
  logic [c_PTR_W-1:0]    r_rd_ptr;
  logic [c_CNT_W-1:0]    r_count;

  logic                  w_in_run;
  logic                  w_full;
  logic                  w_step;
  logic                  w_accept;
  logic                  w_push;
  logic                  w_pop;
  logic [c_ENTRY_W-1:0]  w_head;

  // Fullness uses the start-of-cycle count, so a same-cycle pop never frees a step.
  assign w_in_run = (r_state == S_RUN);
  assign w_full   = (r_count == c_CNT_W'(FIFO_DEPTH));
  assign w_step   = w_in_run & r_sym_vld & ~w_full;
  assign s_ready  = w_in_run & (~r_sym_vld | w_step) & ~r_last_held;
  assign w_accept = s_valid & s_ready;
  assign w_push   = w_step & (|report_vec);
  assign w_pop    = r_valid & r_ready;

  assign ste_run   = w_step;
  assign ste_sod   = w_step & r_cfg;
  assign ste_reset = r_ste_reset;
  assign busy      = r_busy;
  assign done      = r_done;
  assign sym_out   = r_sym;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_sym_vld    <= 1'b0;
      r_last_held  <= 1'b0;
      r_cfg        <= 1'b0;
      r_sym        <= '0;
      r_sym_offset <= '0;
      r_ste_reset  <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (s_valid) begin
            r_state     <= S_CLR;
            r_cfg       <= cfg_all_input;
            r_ste_reset <= 1'b1;
            r_busy      <= 1'b1;
          end
        end
        S_CLR: begin
          r_state      <= S_RUN;
          r_ste_reset  <= 1'b0;
          r_sym_offset <= '0;
          r_sym_vld    <= 1'b0;
          r_last_held  <= 1'b0;
        end
        S_RUN: begin
          if (w_step && r_last_held) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase

      if (w_step) begin
        r_sym_offset <= r_sym_offset + OFFSET_W'(1);
      end

      if (w_accept) begin
        r_sym       <= s_data;
        r_sym_vld   <= 1'b1;
        r_last_held <= s_last;
      end else if (w_step) begin
        r_sym_vld   <= 1'b0;
        r_last_held <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {r_sym_offset, report_vec};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CNT_W'(1);
        2'b01:   r_count <= r_count - c_CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Head fields are masked while empty so stale entries never reach the port.
  assign w_head   = r_mem[r_rd_ptr];
  assign r_valid  = (r_count != '0);
  assign r_offset = r_valid ? w_head[c_ENTRY_W-1:REPORT_W] : '0;
  assign r_bits   = r_valid ? w_head[REPORT_W-1:0] : '0;

endmodule

`default_nettype wire

// File: tb/tb_ste_stream_sequencer.sv
// ============================================================================
// tb_ste_stream_sequencer
//   Directed bench with a queue-based reference model of the sequencer.
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_ste_stream_sequencer;

  localparam int DEPTH = 4;
  localparam int P_IDLE = 0;
  localparam int P_CLR  = 1;
  localparam int P_RUN  = 2;
  localparam int P_DONE = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [7:0]  s_data = '0;
  logic        s_last = 1'b0;
  logic        cfg_all_input = 1'b0;
  logic [7:0]  sym_out;
  logic        ste_run, ste_sod, ste_reset;
  logic [15:0] report_vec;
  logic        r_valid;
  logic        r_ready = 1'b0;
  logic [31:0] r_offset;
  logic [15:0] r_bits;
  logic        busy, done;

  int rv_mode = 0;

  always #5 clk = ~clk;

  ste_stream_sequencer #(
    .SYM_W(8), .REPORT_W(16), .OFFSET_W(32), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .cfg_all_input(cfg_all_input),
    .sym_out(sym_out), .ste_run(ste_run), .ste_sod(ste_sod), .ste_reset(ste_reset),
    .report_vec(report_vec),
    .r_valid(r_valid), .r_ready(r_ready), .r_offset(r_offset), .r_bits(r_bits),
    .busy(busy), .done(done)
  );

  // Stand-in for the STE array: report vector is a pure function of the symbol.
  function automatic logic [15:0] rv_fn(int mode, logic [7:0] s);
    case (mode)
      0:       return (s == 8'h63) ? 16'h0004 : 16'h0000;
      1:       return 16'h0001;
      default: return 16'h0000;
    endcase
  endfunction

  assign report_vec = rv_fn(rv_mode, sym_out);

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic fail_now(string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: bound expired (t=%0t)", name, $time);
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {logic [7:0] sym; logic last;} hsym_t;
  hsym_t       hq[$];
  logic [47:0] rq[$];
  int          m_phase = P_IDLE;
  logic        m_cfg = 1'b0;
  logic [31:0] m_off = '0;
  logic        m_step = 1'b0;
  logic        m_ready = 1'b0;
  hsym_t       m_h;
  logic [15:0] m_rv;
  logic        m_acc;

  int cnt_run = 0, cnt_sod = 0, cnt_rst = 0, cnt_done = 0;
  logic [47:0] rlog[$];

  always @(negedge clk) begin
    if (!rst_n) begin
      m_step  = 1'b0;
      m_ready = 1'b0;
      chk("rst_ste_run",   ste_run,   0);
      chk("rst_ste_sod",   ste_sod,   0);
      chk("rst_ste_reset", ste_reset, 0);
      chk("rst_s_ready",   s_ready,   0);
      chk("rst_busy",      busy,      0);
      chk("rst_done",      done,      0);
      chk("rst_r_valid",   r_valid,   0);
      chk("rst_sym_out",   sym_out,   0);
      chk("rst_r_offset",  r_offset,  0);
      chk("rst_r_bits",    r_bits,    0);
    end else begin
      m_step  = (m_phase == P_RUN) && (hq.size() > 0) && (rq.size() < DEPTH);
      m_ready = (m_phase == P_RUN) && ((hq.size() == 0) || m_step) &&
                !((hq.size() > 0) && hq[0].last);
      chk("ste_run",   ste_run,   m_step);
      chk("ste_sod",   ste_sod,   m_step && m_cfg);
      chk("ste_reset", ste_reset, m_phase == P_CLR);
      chk("s_ready",   s_ready,   m_ready);
      chk("busy",      busy,      m_phase != P_IDLE);
      chk("done",      done,      m_phase == P_DONE);
      chk("r_valid",   r_valid,   rq.size() > 0);
      if (rq.size() > 0) begin
        chk("r_offset", r_offset, rq[0][47:16]);
        chk("r_bits",   r_bits,   rq[0][15:0]);
      end
      if (m_step) chk("sym_out", sym_out, hq[0].sym);
      if (ste_run)   cnt_run++;
      if (ste_sod)   cnt_sod++;
      if (ste_reset) cnt_rst++;
      if (done)      cnt_done++;
      if (r_valid && r_ready) rlog.push_back({r_offset, r_bits});
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hq.delete();
      rq.delete();
      m_phase = P_IDLE;
      m_cfg   = 1'b0;
      m_off   = '0;
    end else begin
      m_acc = s_valid && m_ready;
      m_h   = '0;
      if ((rq.size() > 0) && r_ready) void'(rq.pop_front());
      if (m_step) begin
        m_h  = hq.pop_front();
        m_rv = rv_fn(rv_mode, m_h.sym);
        if (m_rv != 0) rq.push_back({m_off, m_rv});
        m_off = m_off + 1;
      end
      if (m_acc) hq.push_back({s_data, s_last});
      case (m_phase)
        P_IDLE: if (s_valid) begin m_phase = P_CLR; m_cfg = cfg_all_input; end
        P_CLR:  begin m_phase = P_RUN; m_off = '0; end
        P_RUN:  if (m_step && m_h.last) m_phase = P_DONE;
        default: m_phase = P_IDLE;
      endcase
    end
  end

  // ---------------- stimulus ----------------
  bit abort = 1'b0;

  task automatic send_sym(logic [7:0] d, logic l, bit gap);
    int  guard = 0;
    bit  got = 1'b0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    while (!got && !abort && guard < 300) begin
      @(negedge clk);
      got = s_ready;
      @(posedge clk);
      guard++;
    end
    #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
    if (!got && !abort) fail_now("handshake");
    if (gap) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_stream(int n, logic [7:0] base, bit gap);
    for (int i = 0; i < n; i++) begin
      if (abort) break;
      send_sym(8'(base + i), i == n - 1, gap);
    end
  endtask

  task automatic wait_idle();
    int g = 0;
    do begin
      @(negedge clk);
      g++;
    end while (busy && g < 500);
    if (g >= 500) fail_now("wait_idle");
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int g = 0;
    r_ready = 1'b1;
    do begin
      @(negedge clk);
      g++;
    end while (r_valid && g < 100);
    if (g >= 100) fail_now("drain");
    @(posedge clk);
    #1;
  endtask

  int b_run, b_rst, b_done, b_sod, g6;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_sym", sym_out, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: basic stream, single report on 0x63
    rv_mode = 0; r_ready = 1'b1; rlog.delete();
    b_run = cnt_run; b_rst = cnt_rst; b_done = cnt_done;
    send_stream(4, 8'h61, 1'b0);
    wait_idle();
    drain();
    chk("t1_runs",   cnt_run - b_run, 4);
    chk("t1_clr",    cnt_rst - b_rst, 1);
    chk("t1_done",   cnt_done - b_done, 1);
    chk("t1_nrep",   rlog.size(), 1);
    if (rlog.size() > 0) chk("t1_rep", rlog[0], {32'd2, 16'h0004});
    chk("t1_busy",   busy, 0);

    // 2: FIFO fills to depth while consumer stalls, then drains in order
    rv_mode = 1; r_ready = 1'b0; rlog.delete();
    send_stream(4, 8'h61, 1'b0);
    wait_idle();
    chk("t2_held",   rlog.size(), 0);
    chk("t2_rvalid", r_valid, 1);
    drain();
    chk("t2_nrep",   rlog.size(), 4);
    for (int i = 0; i < 4 && i < rlog.size(); i++)
      chk("t2_rep", rlog[i], {32'(i), 16'h0001});

    // 3: backpressure stalls stepping; one pop frees exactly one step
    r_ready = 1'b0; rlog.delete(); b_run = cnt_run;
    fork
      send_stream(6, 8'h61, 1'b0);
      begin
        repeat (30) @(negedge clk);
        chk("t3_stall_runs", cnt_run - b_run, 4);
        chk("t3_hold_sym",   sym_out, 8'h65);
        chk("t3_busy",       busy, 1);
        @(posedge clk); #1; r_ready = 1'b1;
        @(posedge clk); #1; r_ready = 1'b0;
        repeat (10) @(negedge clk);
        chk("t3_one_more",   cnt_run - b_run, 5);
        @(posedge clk); #1; r_ready = 1'b1;
      end
    join
    wait_idle();
    drain();
    chk("t3_nrep", rlog.size(), 6);
    for (int i = 0; i < 6 && i < rlog.size(); i++)
      chk("t3_rep_off", rlog[i][47:16], 32'(i));

    // 4: gappy input; gaps are not symbols
    rv_mode = 1; r_ready = 1'b1; rlog.delete(); b_run = cnt_run;
    send_stream(6, 8'h41, 1'b1);
    wait_idle();
    drain();
    chk("t4_runs", cnt_run - b_run, 6);
    chk("t4_nrep", rlog.size(), 6);
    for (int i = 0; i < 6 && i < rlog.size(); i++)
      chk("t4_rep_off", rlog[i][47:16], 32'(i));

    // 5: all-input start semantics latched at stream start
    rv_mode = 2; cfg_all_input = 1'b1; b_sod = cnt_sod; b_run = cnt_run;
    fork
      send_stream(4, 8'h30, 1'b0);
      begin repeat (4) @(posedge clk); #1; cfg_all_input = 1'b0; end
    join
    wait_idle();
    chk("t5_sod_on",  cnt_sod - b_sod, 4);
    chk("t5_run_on",  cnt_run - b_run, 4);
    cfg_all_input = 1'b0; b_sod = cnt_sod;
    fork
      send_stream(4, 8'h30, 1'b0);
      begin repeat (4) @(posedge clk); #1; cfg_all_input = 1'b1; end
    join
    wait_idle();
    cfg_all_input = 1'b0;
    chk("t5_sod_off", cnt_sod - b_sod, 0);

    // 6: async reset after the second step
    rv_mode = 1; r_ready = 1'b1; abort = 1'b0; b_run = cnt_run;
    fork
      send_stream(4, 8'h71, 1'b0);
      begin
        g6 = 0;
        while (cnt_run < b_run + 2 && g6 < 100) begin @(negedge clk); g6++; end
        if (g6 >= 100) fail_now("t6_wait_steps");
        @(posedge clk); #1;
        rst_n = 1'b0;
        abort = 1'b1;
        #1;
        chk("t6_busy",    busy, 0);
        chk("t6_sym",     sym_out, 0);
        chk("t6_run",     ste_run, 0);
        chk("t6_rvalid",  r_valid, 0);
        chk("t6_sready",  s_ready, 0);
      end
    join
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1; abort = 1'b0; rlog.delete(); b_rst = cnt_rst;
    send_stream(3, 8'h51, 1'b0);
    wait_idle();
    drain();
    chk("t6_clr",   cnt_rst - b_rst, 1);
    chk("t6_nrep",  rlog.size(), 3);
    if (rlog.size() > 0) chk("t6_first", rlog[0], {32'd0, 16'h0001});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
